// File: rtl/proj_fm_ram.sv
// Multi-buffered feature-map RAM.
// Words are written linearly into one buffer. When that buffer is full, it becomes
// the read buffer, and a registered R-word window sweeps across it, wrapping
// within the same buffer.
module proj_fm_ram #(
    parameter int unsigned BUFFER_COUNT         = 2,
    parameter int unsigned RAMS                 = 2,
    parameter int unsigned ENTRIES              = 2,
    parameter int unsigned OFFSET               = 2,
    parameter int unsigned DATA_BITS            = 8,
    parameter int unsigned READ_ADDRESSES_COUNT = 2
) (
    input  logic                                      in_clk,
    input  logic                                      in_rst_n,
    input  logic [DATA_BITS-1:0]                      in_wdata,
    output logic [READ_ADDRESSES_COUNT*DATA_BITS-1:0] out_rdata
);

    localparam int unsigned N   = RAMS * ENTRIES * OFFSET;
    localparam int unsigned EO  = ENTRIES * OFFSET;
    localparam int unsigned R   = READ_ADDRESSES_COUNT;
    localparam int unsigned OW  = R * DATA_BITS;
    localparam int unsigned BW  = (BUFFER_COUNT > 1) ? $clog2(BUFFER_COUNT) : 1;
    localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BKW = (RAMS > 1) ? $clog2(RAMS) : 1;
    localparam int unsigned ENW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int unsigned OFW = (OFFSET > 1) ? $clog2(OFFSET) : 1;

    // Split a linear word address into bank, entry and offset.
    function automatic logic [BKW-1:0] bank_of(input int unsigned a);
        return BKW'(a / EO);
    endfunction

    function automatic logic [ENW-1:0] entry_of(input int unsigned a);
        return ENW'((a / OFFSET) % ENTRIES);
    endfunction

    function automatic logic [OFW-1:0] offset_of(input int unsigned a);
        return OFW'(a % OFFSET);
    endfunction

    logic [DATA_BITS-1:0] mem_q [BUFFER_COUNT][RAMS][ENTRIES][OFFSET];

    logic [BW-1:0] wr_idx_q, wr_idx_d;
    logic [BW-1:0] rd_idx_q, rd_idx_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          rd_valid_q, rd_valid_d;
    logic [OW-1:0] rdata_q, rdata_d;
    logic          frame_done_c;

    // Storage has no reset. A write during reset can only hit word 0 of buffer 0.
    // That word is the first one rewritten after release.
    always_ff @(posedge in_clk) begin
        mem_q[wr_idx_q][bank_of(32'(wr_ptr_q))][entry_of(32'(wr_ptr_q))][offset_of(32'(wr_ptr_q))] <= in_wdata;
    end

    // Pointer and buffer sequencing. Buffer completion overrides the read-pointer step.
    always_comb begin
        wr_idx_d     = wr_idx_q;
        rd_idx_d     = rd_idx_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        rd_valid_d   = rd_valid_q;
        frame_done_c = (wr_ptr_q == PW'(N - 1));

        if (frame_done_c) begin
            wr_ptr_d   = '0;
            wr_idx_d   = (wr_idx_q == BW'(BUFFER_COUNT - 1)) ? '0 : wr_idx_q + BW'(1);
            rd_idx_d   = wr_idx_q;
            rd_ptr_d   = '0;
            rd_valid_d = 1'b1;
        end else begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (rd_valid_q) begin
                rd_ptr_d = (rd_ptr_q == PW'(N - 1)) ? '0 : rd_ptr_q + PW'(1);
            end
        end
    end

    // Read window: lane k reads rd_ptr+k of the read buffer, wrapping inside it.
    always_comb begin
        int unsigned a;
        a       = 0;
        rdata_d = '0;
        if (rd_valid_q) begin
            for (int unsigned k = 0; k < R; k++) begin
                a = 32'(rd_ptr_q) + k;
                if (a >= N) begin
                    a = a - N;
                end
                rdata_d[k*DATA_BITS +: DATA_BITS] = mem_q[rd_idx_q][bank_of(a)][entry_of(a)][offset_of(a)];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            wr_idx_q   <= '0;
            rd_idx_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            wr_idx_q   <= wr_idx_d;
            rd_idx_q   <= rd_idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rd_valid_q <= rd_valid_d;
            rdata_q    <= rdata_d;
        end
    end

    assign out_rdata = rdata_q;

endmodule

// File: tb/tb_proj_fm_ram.sv
// Scoreboard bench for proj_fm_ram.
// Two DUTs run side by side: the default build (R=2, two buffers) and a build with
// R=3 and three buffers.
module tb_proj_fm_ram;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  wdata;
    logic [15:0] rdata2;
    logic [23:0] rdata3;

    always #5 clk = ~clk;

    proj_fm_ram u_dut2 (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_wdata  (wdata),
        .out_rdata (rdata2)
    );

    proj_fm_ram #(
        .BUFFER_COUNT         (3),
        .READ_ADDRESSES_COUNT (3)
    ) u_dut3 (
        .in_clk    (clk),
        .in_rst_n  (rst_n),
        .in_wdata  (wdata),
        .out_rdata (rdata3)
    );

    logic [39:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;
    bit stim_done = 1'b0;

    // Hand-computed windows for the first frame of the first run, plus the first buffer-1 window.
    logic [15:0] tbl2 [9] = '{16'h0100, 16'h0201, 16'h0302, 16'h0403, 16'h0504,
                              16'h0605, 16'h0706, 16'h0007, 16'h0908};

    task automatic chk(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected window after edge e since release.
    // Data is base+(e-1) with contiguous frames of 8 words, so frame f holds base+8f..base+8f+7.
    function automatic logic [23:0] win(input int e, input int base, input int r);
        logic [23:0] w;
        int f;
        int j;
        w = '0;
        if (e > 8) begin
            f = (e - 9) / 8;
            j = (e - 9) % 8;
            for (int k = 0; k < r; k++) begin
                w[k*8 +: 8] = 8'(base + 8 * f + (j + k) % 8);
            end
        end
        return w;
    endfunction

    // One clock: drive at the negedge, queue the response due at the next posedge.
    task automatic cycle(input logic [7:0] d, input logic [15:0] e2, input logic [23:0] e3);
        wdata = d;
        exp_q.push_back({e3, e2});
        @(negedge clk);
    endtask

    task automatic run_frames(input int base, input int n_edges, input bit use_tbl);
        logic [15:0] e2;
        for (int e = 1; e <= n_edges; e++) begin
            e2 = win(e, base, 2)[15:0];
            if (use_tbl && e >= 9 && e <= 17) begin
                e2 = tbl2[e - 9];
            end
            cycle(8'(base + e - 1), e2, win(e, base, 3));
        end
    endtask

    // Monitor: compare every registered output against the scoreboard.
    initial begin
        logic [39:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("rdata_r2", {8'h00, rdata2}, {8'h00, e[15:0]});
                chk("rdata_r3", rdata3, e[39:16]);
            end
        end
    end

    // Stimulus.
    initial begin
        rst_n = 1'b1;
        wdata = 8'h00;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_r2", {8'h00, rdata2}, 24'h0);
        chk("reset_r3", rdata3, 24'h0);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            cycle((i % 2 == 0) ? 8'hA5 : 8'h5A, 16'h0, 24'h0);
        end
        rst_n = 1'b1;

        // Eight frames of data i+8*frame, then one frame of read-out.
        run_frames(0, 72, 1'b1);

        // Restart, then reset asynchronously in the middle of writing frame 2.
        rst_n = 1'b0;
        #1;
        chk("rst2_r2", {8'h00, rdata2}, 24'h0);
        chk("rst2_r3", rdata3, 24'h0);
        @(negedge clk);
        cycle(8'h33, 16'h0, 24'h0);
        cycle(8'h44, 16'h0, 24'h0);
        rst_n = 1'b1;
        run_frames(8'h40, 20, 1'b0);

        wdata = 8'hEE;
        exp_q.push_back('0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_r2", {8'h00, rdata2}, 24'h0);
        chk("midrst_r3", rdata3, 24'h0);
        @(negedge clk);
        cycle(8'h11, 16'h0, 24'h0);
        cycle(8'h22, 16'h0, 24'h0);
        rst_n = 1'b1;
        run_frames(8'h80, 32, 1'b0);

        // Drain the scoreboard.
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "timeout");
        end
    end

endmodule
